fifo_rd_stream: RTL

- Read-side consumer for the dual-clock FIFO; lives entirely in the rclk domain.
- Pops words from the FIFO read port (rinc/rempty/rdata) and presents them downstream on a registered valid/ready stream.
- Uses a 2-entry output buffer so that neither rempty nor m_ready has a combinational path to the outputs.
- Adds enable and flush control so software can pause or drain the FIFO.

---
 rtl/fifo_rd_pkg.sv | 13 +
 rtl/fifo_rd_skid.sv | 64 ++++++
 rtl/fifo_rd_stream.sv | 117 +++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the dual-clock FIFO read-side stream consumer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

  localparam int OCC_W     = 2;
  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: head drives the registered stream outputs, tail
// absorbs one extra word so push never has to look at downstream ready.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [OCC_W-1:0] occ,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data
);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;

  // Next buffer contents: pop first, then push into the first free slot, clear last.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (pop && (occ_q != '0)) begin
      // Shifting tail into head when occ was 1 loads a stale word, but m_valid
      // is low then, so it is never observed as data.
      head_d = tail_q;
      occ_d  = occ_q - 1'b1;
    end
    if (push && (occ_d < OCC_W'(BUF_DEPTH))) begin
      if (occ_d == '0) begin
        head_d = push_data;
      end else begin
        tail_d = push_data;
      end
      occ_d = occ_d + 1'b1;
    end
    if (clear) begin
      occ_d = '0;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign occ     = occ_q;
  assign m_valid = (occ_q != '0);
  assign m_data  = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the dual-clock FIFO (rclk domain). Pops FIFO words
// into a 2-entry buffer and presents them on a registered valid/ready stream,
// with enable and flush control.
// Optional popped-word statistics counter: define FIFO_RD_STATS_EN.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             busy
`ifdef FIFO_RD_STATS_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] pop_cnt
`endif
);

  rd_state_e        state_q, state_d;
  logic [OCC_W-1:0] occ;
  logic             push;
  logic             xfer;
  logic             clear;

  // State register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: flush wins from any state; FLUSH exits only once the FIFO is drained.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        IDLE:    state_d = en ? RUN : IDLE;
        RUN:     state_d = en ? RUN : IDLE;
        FLUSH:   state_d = rempty ? IDLE : FLUSH;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: pop strobe never depends on m_ready and is never raised while rempty=1.
  always_comb begin
    rinc = 1'b0;
    busy = 1'b0;
    unique case (state_q)
      RUN:     rinc = !rempty && (occ < OCC_W'(BUF_DEPTH));
      FLUSH: begin
        rinc = !rempty;
        busy = 1'b1;
      end
      default: rinc = 1'b0;
    endcase
  end

  // Words popped during FLUSH are discarded by not pushing them.
  assign push  = rinc && (state_q == RUN);
  assign xfer  = m_valid && m_ready;
  assign clear = (state_d == FLUSH);

  fifo_rd_skid #(
    .DSIZE(DSIZE)
  ) u_skid (
    .clk      (rclk),
    .rst_n    (rrst_n),
    .push     (push),
    .push_data(rdata),
    .pop      (xfer),
    .clear    (clear),
    .occ      (occ),
    .m_valid  (m_valid),
    .m_data   (m_data)
  );

`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Transfer counter: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (xfer && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pop_cnt = cnt_q;
`endif

endmodule
